// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch prefetch stage.
//   IF_DATA_WIDTH / IF_FIFO_DEPTH : default PC/instruction width and number of
//                                   prefetch entries
//   branch_ctrl_e                 : encoding of the branch_ctrl input
//   fetch_entry_t                 : one prefetch FIFO entry {pc, instr}
// ---------------------------------------------------------------------------
package if_pkg;

   localparam int IF_DATA_WIDTH = 32;
   localparam int IF_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      BR_RS1_IMM = 2'd0,   // jalr target
      BR_PC_IMM  = 2'd1,   // pc-relative branch / jal target
      BR_SEQ     = 2'd2,   // keep fetching sequentially
      BR_RESET   = 2'd3    // restart at the reset vector
   } branch_ctrl_e;

   typedef struct packed {
      logic [IF_DATA_WIDTH-1:0] pc;
      logic [IF_DATA_WIDTH-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// ---------------------------------------------------------------------------
// if_fetch_fifo
// Generic synchronous FIFO with a combinational head read (first-word
// fall-through), so the head entry is visible the cycle after it is written.
//   clk, srst  : clock, synchronous active-high reset
//   push       : write push_data (accepted when not full, or when a pop
//                happens in the same cycle)
//   pop        : remove the head (ignored when empty)
//   clear      : drop all entries; wins over push and pop
//   head_data  : current head entry
//   full/empty : status flags
//   count      : number of stored entries, 0..DEPTH
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module if_fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(DEPTH + 1),
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             clear,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             push_en;
   logic             pop_en;

   assign full    = (count_reg == DEPTH_C);
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign pop_en  = pop && !empty;
   // A simultaneous pop frees the slot, so a full FIFO still accepts a push.
   assign push_en = push && (!full || pop_en);

   always_ff @(posedge clk) begin
      if (srst || clear) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_en) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop_en) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         count_reg <= count_reg + CW'(push_en) - CW'(pop_en);
      end
   end

   // Storage carries no reset; validity is tracked by count_reg alone.
   always_ff @(posedge clk) begin
      if (push_en && !clear && !srst) begin
         mem_reg[wr_ptr_reg] <= push_data;
      end
   end

   assign head_data = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/if_prefetch_stage.sv
// ---------------------------------------------------------------------------
// if_prefetch_stage
// Instruction-fetch stage with a decoupled instruction-memory interface and an
// in-order prefetch FIFO of {pc, instr} entries feeding the IF/ID register.
//   clk, rst             : clock, synchronous active-high reset
//   branch_ctrl          : 0 jalr target, 1 pc-relative target, 2 sequential,
//                          3 restart at RESET_PC
//   pc_mux_imm_rs1/imm   : redirect targets
//   im_req_valid/ready   : fetch request handshake, im_req_addr = fetch PC
//   im_rsp_valid/instr   : in-order instruction return (latency >= 1)
//   id_ready             : ID consumes the head entry
//   instr_flush_sel      : combinationally masks if_instr to FLUSH_INSTR
//   if_valid/pc/instr    : FIFO head towards the IF/ID register
// Requests are only issued while fifo_count + outstanding < FIFO_DEPTH, so
// every returning response always has a free FIFO slot. On a redirect the
// responses still in flight are counted in drop_cnt and discarded on return.
// The entry FIFO stores fetch_entry_t, so DATA_WIDTH must equal
// if_pkg::IF_DATA_WIDTH.
// ---------------------------------------------------------------------------
module if_prefetch_stage
   import if_pkg::*;
#(
   parameter int                    DATA_WIDTH  = IF_DATA_WIDTH,
   parameter int                    FIFO_DEPTH  = IF_FIFO_DEPTH,
   parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
   parameter logic [DATA_WIDTH-1:0] FLUSH_INSTR = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            branch_ctrl,
   input  logic [DATA_WIDTH-1:0] pc_mux_imm_rs1,
   input  logic [DATA_WIDTH-1:0] pc_mux_imm,
   output logic                  im_req_valid,
   input  logic                  im_req_ready,
   output logic [DATA_WIDTH-1:0] im_req_addr,
   input  logic                  im_rsp_valid,
   input  logic [DATA_WIDTH-1:0] im_rsp_instr,
   input  logic                  id_ready,
   input  logic                  instr_flush_sel,
   output logic                  if_valid,
   output logic [DATA_WIDTH-1:0] if_pc,
   output logic [DATA_WIDTH-1:0] if_instr
);

   localparam int              CW           = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0]   DEPTH_C      = CW'(FIFO_DEPTH);
   localparam logic [CW:0]     DEPTH_CREDIT = (CW + 1)'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] fetch_pc_reg;
   logic [DATA_WIDTH-1:0] fetch_pc_next;
   logic [CW-1:0]         outstanding_reg;
   logic [CW-1:0]         outstanding_next;
   logic [CW-1:0]         drop_cnt_reg;
   logic [CW-1:0]         drop_cnt_next;
   logic                  rst_hold_reg;    // keeps requests off the cycle after reset

   logic                  redirect;
   logic                  req_fire;
   logic                  rsp_drop;
   logic                  entry_push;
   logic                  entry_pop;
   logic [CW:0]           credit_used;

   fetch_entry_t          entry_in;
   fetch_entry_t          entry_head;
   logic [CW-1:0]         entry_count;
   logic                  entry_full;
   logic                  entry_empty;

   logic [DATA_WIDTH-1:0] pcq_head;
   logic [CW-1:0]         pcq_count;
   logic                  pcq_full;
   logic                  pcq_empty;
   logic                  unused_status;

   // ------------------------------------------------------------------
   // Control: credit, handshakes, redirect bookkeeping
   // ------------------------------------------------------------------
   always_comb begin
      redirect         = (branch_ctrl != BR_SEQ);
      credit_used      = {1'b0, entry_count} + {1'b0, outstanding_reg};
      // Credit uses only registered state: no path from id_ready.
      im_req_valid     = !rst && !rst_hold_reg && (credit_used < DEPTH_CREDIT);
      req_fire         = im_req_valid && im_req_ready;
      outstanding_next = outstanding_reg + CW'(req_fire) - CW'(im_rsp_valid);
      rsp_drop         = (drop_cnt_reg != '0);
      // A response in the redirect cycle belongs to the old stream.
      entry_push       = im_rsp_valid && !rsp_drop && !redirect;
      entry_pop        = if_valid && id_ready && !redirect;

      entry_in.pc      = pcq_head;
      entry_in.instr   = im_rsp_instr;

      // Everything still in flight after this edge is stale on a redirect,
      // including a request handshaked in this very cycle.
      if (redirect) begin
         drop_cnt_next = outstanding_next;
      end else if (im_rsp_valid && rsp_drop) begin
         drop_cnt_next = drop_cnt_reg - CW'(1);
      end else begin
         drop_cnt_next = drop_cnt_reg;
      end

      case (branch_ctrl)
         BR_RS1_IMM: fetch_pc_next = pc_mux_imm_rs1;
         BR_PC_IMM:  fetch_pc_next = pc_mux_imm;
         BR_RESET:   fetch_pc_next = RESET_PC;
         default:    fetch_pc_next = req_fire ? (fetch_pc_reg + DATA_WIDTH'(4)) : fetch_pc_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_reg    <= RESET_PC;
         outstanding_reg <= '0;
         drop_cnt_reg    <= '0;
         rst_hold_reg    <= 1'b1;
      end else begin
         fetch_pc_reg    <= fetch_pc_next;
         outstanding_reg <= outstanding_next;
         drop_cnt_reg    <= drop_cnt_next;
         rst_hold_reg    <= 1'b0;
      end
   end

   assign im_req_addr = fetch_pc_reg;

   // ------------------------------------------------------------------
   // Prefetch FIFO of {pc, instr}; cleared on redirect
   // ------------------------------------------------------------------
   if_fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_entry_fifo (
      .clk       (clk),
      .srst      (rst),
      .push      (entry_push),
      .push_data (entry_in),
      .pop       (entry_pop),
      .clear     (redirect),
      .head_data (entry_head),
      .full      (entry_full),
      .empty     (entry_empty),
      .count     (entry_count)
   );

   // ------------------------------------------------------------------
   // In-flight PC queue: one entry per handshaked request, popped by every
   // response (kept or dropped), so its head is always the PC of the
   // returning instruction. Never cleared by a redirect.
   // ------------------------------------------------------------------
   if_fetch_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_pc_queue (
      .clk       (clk),
      .srst      (rst),
      .push      (req_fire),
      .push_data (fetch_pc_reg),
      .pop       (im_rsp_valid),
      .clear     (1'b0),
      .head_data (pcq_head),
      .full      (pcq_full),
      .empty     (pcq_empty),
      .count     (pcq_count)
   );

   assign unused_status = ^{entry_full, pcq_full, pcq_empty};

   // ------------------------------------------------------------------
   // ID-facing outputs (all from registered FIFO state)
   // ------------------------------------------------------------------
   assign if_valid = !rst && !entry_empty;
   assign if_pc    = if_valid ? entry_head.pc : '0;
   assign if_instr = (instr_flush_sel || !if_valid) ? FLUSH_INSTR : entry_head.instr;

   a_outstanding_bound : assert property (@(posedge clk) disable iff (rst)
      outstanding_reg <= DEPTH_C);

   a_pc_queue_tracks : assert property (@(posedge clk) disable iff (rst)
      pcq_count == outstanding_reg);

endmodule

// File: tb/tb_if_prefetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_prefetch_stage
// Drives the fetch stage against a behavioural instruction memory with a
// configurable latency. Every issued request is tagged with the current fetch
// epoch (bumped by each redirect); a returning response whose epoch is still
// current is pushed to the expected-entry queue and later compared with what
// the stage presents to ID. Request addresses come from an independent model
// of the fetch PC.
// ---------------------------------------------------------------------------
module tb_if_prefetch_stage;
   import if_pkg::*;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] FLUSH    = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  branch_ctrl;
   logic [31:0] pc_mux_imm_rs1;
   logic [31:0] pc_mux_imm;
   logic        im_req_valid;
   logic        im_req_ready;
   logic [31:0] im_req_addr;
   logic        im_rsp_valid;
   logic [31:0] im_rsp_instr;
   logic        id_ready;
   logic        instr_flush_sel;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;

   always #5 clk = ~clk;

   if_prefetch_stage #(
      .DATA_WIDTH  (32),
      .FIFO_DEPTH  (DEPTH),
      .RESET_PC    (RESET_PC),
      .FLUSH_INSTR (FLUSH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .branch_ctrl     (branch_ctrl),
      .pc_mux_imm_rs1  (pc_mux_imm_rs1),
      .pc_mux_imm      (pc_mux_imm),
      .im_req_valid    (im_req_valid),
      .im_req_ready    (im_req_ready),
      .im_req_addr     (im_req_addr),
      .im_rsp_valid    (im_rsp_valid),
      .im_rsp_instr    (im_rsp_instr),
      .id_ready        (id_ready),
      .instr_flush_sel (instr_flush_sel),
      .if_valid        (if_valid),
      .if_pc           (if_pc),
      .if_instr        (if_instr)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   typedef struct {
      logic [31:0] exp_pc;
      logic [31:0] dut_addr;
      int          epoch;
      int          due;
   } pend_t;

   pend_t        pend_q[$];   // requests in flight inside the memory model
   fetch_entry_t exp_q[$];    // expected prefetch FIFO contents

   logic [31:0] model_pc;
   int          epoch;
   bit          hold;
   int          cyc;
   int          lat;

   // stimulus knobs
   logic        drv_rst;
   logic [1:0]  drv_br;
   logic [31:0] drv_rs1;
   logic [31:0] drv_imm;
   bit          drv_ready_rand;
   bit          drv_id_rand;
   logic        drv_id_ready;
   logic        drv_flush;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[15:0] ^ 16'h1234, ~a[15:0]};
   endfunction

   task automatic cycle();
      pend_t        p;
      pend_t        r;
      fetch_entry_t e;
      logic         exp_req_valid;
      logic         exp_if_valid;
      logic [31:0]  exp_pc_out;
      logic [31:0]  exp_instr_out;
      bit           redirect;
      bit           hs;
      bit           rsp;

      @(negedge clk);
      rst             = drv_rst;
      branch_ctrl     = drv_br;
      pc_mux_imm_rs1  = drv_rs1;
      pc_mux_imm      = drv_imm;
      im_req_ready    = drv_ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      id_ready        = drv_id_rand ? 1'($urandom_range(0, 1)) : drv_id_ready;
      instr_flush_sel = drv_flush;
      rsp             = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
      im_rsp_valid    = rsp;
      im_rsp_instr    = rsp ? instr_of(pend_q[0].dut_addr) : 32'hDEAD_BEEF;
      #1;

      redirect      = (drv_br != BR_SEQ);
      exp_req_valid = !drv_rst && !hold && ((exp_q.size() + pend_q.size()) < DEPTH);
      exp_if_valid  = !drv_rst && (exp_q.size() > 0);
      exp_pc_out    = 32'h0;
      exp_instr_out = FLUSH;
      if (exp_if_valid) begin
         exp_pc_out = exp_q[0].pc;
         if (!drv_flush) exp_instr_out = exp_q[0].instr;
      end
      check_eq("im_req_valid", 32'(im_req_valid), 32'(exp_req_valid));
      check_eq("if_valid", 32'(if_valid), 32'(exp_if_valid));
      check_eq("if_pc", if_pc, exp_pc_out);
      check_eq("if_instr", if_instr, exp_instr_out);

      hs = im_req_valid && im_req_ready;
      if (drv_rst) begin
         pend_q.delete();
         exp_q.delete();
         model_pc = RESET_PC;
         hold     = 1'b1;
         epoch++;
      end else begin
         if (hs) begin
            check_eq("im_req_addr", im_req_addr, model_pc);
            p.exp_pc   = model_pc;
            p.dut_addr = im_req_addr;
            p.epoch    = epoch;
            p.due      = cyc + lat;
            model_pc   = model_pc + 32'd4;
         end
         if (exp_if_valid && id_ready && !redirect) begin
            $display("POP   pc=%h instr=%h flush=%0d", if_pc, if_instr, drv_flush);
            void'(exp_q.pop_front());
         end
         if (rsp) begin
            r = pend_q.pop_front();
            if (r.epoch == epoch && !redirect) begin
               e.pc    = r.exp_pc;
               e.instr = instr_of(r.exp_pc);
               exp_q.push_back(e);
            end
         end
         if (hs) pend_q.push_back(p);
         if (redirect) begin
            exp_q.delete();
            epoch++;
            case (drv_br)
               2'd0:    model_pc = drv_rs1;
               2'd1:    model_pc = drv_imm;
               default: model_pc = RESET_PC;
            endcase
            $display("REDIR ctrl=%0d target=%h", drv_br, model_pc);
         end
         hold = 1'b0;
      end
      cyc++;
   endtask

   task automatic redirect_once(input logic [1:0] br, input logic [31:0] target);
      drv_br  = br;
      drv_rs1 = target;
      drv_imm = target;
      cycle();
      drv_br  = BR_SEQ;
   endtask

   initial begin
      rst             = 1'b1;
      branch_ctrl     = BR_SEQ;
      pc_mux_imm_rs1  = '0;
      pc_mux_imm      = '0;
      im_req_ready    = 1'b1;
      im_rsp_valid    = 1'b0;
      im_rsp_instr    = '0;
      id_ready        = 1'b1;
      instr_flush_sel = 1'b0;
      drv_rst         = 1'b1;
      drv_br          = BR_SEQ;
      drv_rs1         = '0;
      drv_imm         = '0;
      drv_ready_rand  = 1'b0;
      drv_id_rand     = 1'b0;
      drv_id_ready    = 1'b1;
      drv_flush       = 1'b0;
      model_pc        = RESET_PC;
      epoch           = 0;
      hold            = 1'b1;
      cyc             = 0;
      lat             = 1;

      // reset, then a sequential stream with 1-cycle memory latency
      repeat (3) cycle();
      drv_rst = 1'b0;
      repeat (20) cycle();

      // ID stall: FIFO fills to DEPTH entries, requests stop, then drain
      drv_id_ready = 1'b0;
      repeat (10) cycle();
      drv_id_ready = 1'b1;
      repeat (10) cycle();

      // pc-relative redirect with several requests in flight (latency 3)
      lat = 3;
      repeat (10) cycle();
      redirect_once(BR_PC_IMM, 32'h0000_0100);
      repeat (15) cycle();

      // jalr redirect in a cycle with a response and a pop
      lat = 1;
      repeat (8) cycle();
      redirect_once(BR_RS1_IMM, 32'h0000_2000);
      repeat (10) cycle();

      // back-to-back redirects while drops are pending
      lat = 3;
      repeat (6) cycle();
      redirect_once(BR_PC_IMM, 32'h0000_0040);
      redirect_once(BR_RS1_IMM, 32'h0000_0080);
      repeat (15) cycle();

      // address wrap at the top of the space, then flush masking
      lat = 1;
      redirect_once(BR_PC_IMM, 32'hFFFF_FFF8);
      repeat (6) cycle();
      drv_flush = 1'b1;
      repeat (4) cycle();
      drv_flush = 1'b0;
      repeat (4) cycle();

      // random memory and ID back-pressure
      lat            = 2;
      drv_ready_rand = 1'b1;
      drv_id_rand    = 1'b1;
      repeat (40) cycle();
      drv_ready_rand = 1'b0;
      drv_id_rand    = 1'b0;
      repeat (8) cycle();

      // restart at the reset vector via branch_ctrl
      redirect_once(BR_RESET, 32'h0000_0000);
      repeat (10) cycle();

      // reset in the middle of a stream
      lat = 2;
      redirect_once(BR_PC_IMM, 32'h0000_0800);
      repeat (7) cycle();
      drv_rst = 1'b1;
      cycle();
      drv_rst = 1'b0;
      repeat (12) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
